ysyx_22041207_ifu: RTL and testbench



---
 rtl/ysyx_22041207_ifu_pkg.sv | 22 ++
 rtl/ysyx_22041207_ifu_fifo.sv | 52 +++++
 rtl/ysyx_22041207_ifu.sv | 150 +++++++++++++++
 tb/tb_ysyx_22041207_ifu.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_ifu_pkg.sv
// Shared types and constants for the ysyx_22041207 instruction fetch unit.
package ysyx_22041207_ifu_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] IFU_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic              misalign;
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ysyx_22041207_ifu_fifo.sv
// Synchronous FIFO for fetched {misalign, pc, inst} entries; flush beats push/pop.
module ysyx_22041207_ifu_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch: owns the PC, one outstanding imem read, buffered output to decode.
// Optional YSYX_22041207_IFU_MISALIGN_EN: misaligned redirect yields a nop marker entry.
module ysyx_22041207_ifu
  import ysyx_22041207_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = IFU_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              fetch_misalign
);

  // state | meaning
  // IDLE  | no request in flight; issue when buffer has room, or emit marker
  // REQ   | request held on imem port until accepted
  // WAIT  | request accepted, waiting for its single response

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d;
  logic            drop_q, drop_d, halt_q, halt_d, mark_q, mark_d;
  logic            push, flush, pop, fifo_valid;
  ifu_entry_t      push_entry, head;
  logic [CW-1:0]   fifo_cnt;
  logic [XLEN-1:0] redir_pc;
  logic            redir_mis;

`ifdef YSYX_22041207_IFU_MISALIGN_EN
  assign redir_pc  = redirect_pc;
  assign redir_mis = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc  = redirect_pc & ~64'h3;
  assign redir_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IFU_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      halt_q  <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      halt_q  <= halt_d;
      mark_q  <= mark_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    halt_d     = halt_q;
    mark_d     = mark_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_entry = '0;

    unique case (state_q)
      IFU_IDLE: begin
        if (mark_q) begin
          push       = 1'b1;
          push_entry = '{misalign: 1'b1, pc: pc_q, inst: IFU_NOP};
          mark_d     = 1'b0;
        end else if (!halt_q && (fifo_cnt < DEPTH_C)) begin
          state_d = IFU_REQ;
          addr_d  = pc_q;
        end
      end
      IFU_REQ: begin
        if (imem_req_ready) state_d = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (imem_resp_valid) begin
          state_d = IFU_IDLE;
          drop_d  = 1'b0;
          if (!drop_q) begin
            push       = 1'b1;
            push_entry = '{misalign: 1'b0, pc: addr_q, inst: imem_resp_data};
            pc_d       = pc_q + 64'd4;
          end
        end
      end
      default: state_d = IFU_IDLE;
    endcase

    // A response consumed in the redirect cycle must not leave drop set,
    // otherwise the first fetch at the new target would be thrown away.
    if (redirect_valid) begin
      flush  = 1'b1;
      push   = 1'b0;
      pc_d   = redir_pc;
      halt_d = redir_mis;
      mark_d = redir_mis;
      if (state_q == IFU_IDLE) begin
        state_d = IFU_IDLE;
        addr_d  = addr_q;
      end else if ((state_q == IFU_WAIT) && imem_resp_valid) begin
        drop_d = 1'b0;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  assign pop = inst_valid && inst_ready && !redirect_valid;

  ysyx_22041207_ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(ifu_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign imem_req_valid = (state_q == IFU_REQ);
  assign imem_req_addr  = addr_q;
  assign inst_valid     = fifo_valid;
  assign inst           = fifo_valid ? head.inst : '0;
  assign inst_pc        = fifo_valid ? head.pc   : '0;
  assign fetch_misalign = fifo_valid && head.misalign;

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Directed self-checking bench for ysyx_22041207_ifu with a simple latency-programmable imem model.
module tb_ysyx_22041207_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fetch_misalign;

  int          n_chk = 0;
  int          n_err = 0;
  int          mem_lat;
  logic [3:0]  pend;
  logic [63:0] paddr;
  logic [63:0] req_log [$];
  logic [63:0] pop_pc  [$];
  logic [31:0] pop_inst[$];

  always #5 clk = ~clk;

  ysyx_22041207_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fetch_misalign  (fetch_misalign)
  );

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Memory: exactly one response per accepted request, mem_lat extra cycles later.
  always @(posedge clk) begin
    if (!rst_n) begin
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= '0;
      pend            <= '0;
      paddr           <= '0;
    end else begin
      imem_resp_valid <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        if (mem_lat == 0) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= word(imem_req_addr);
        end else begin
          pend  <= 4'(mem_lat);
          paddr <= imem_req_addr;
        end
      end else if (pend != 0) begin
        pend <= pend - 4'd1;
      end
      if (pend == 4'd1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= word(paddr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      pop_pc.push_back(inst_pc);
      pop_inst.push_back(inst);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int lat, input logic mready, input logic iready);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = lat;
    imem_req_ready = mready;
    inst_ready     = iready;
    step(3);
    req_log.delete();
    pop_pc.delete();
    pop_inst.delete();
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    bit hit;

    // Reset values
    hold_reset(0, 1'b1, 1'b1);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr",  imem_req_addr,       64'd0);
    chk("rst_inst_valid", 64'(inst_valid),    64'd0);
    chk("rst_inst",      64'(inst),           64'd0);
    chk("rst_inst_pc",   inst_pc,             64'd0);
    chk("rst_misalign",  64'(fetch_misalign), 64'd0);

    // Sequential fetch, ready memory, ready decoder
    rst_n = 1'b1;
    step(1);
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr",  imem_req_addr,       64'h8000_0000);
    step(19);
    chk("seq_req_n", 64'(req_log.size() >= 3), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("seq_req%0d", i),  req_log[i],       64'h8000_0000 + 64'(4 * i));
      chk($sformatf("seq_pc%0d", i),   pop_pc[i],        64'h8000_0000 + 64'(4 * i));
      chk($sformatf("seq_inst%0d", i), 64'(pop_inst[i]), 64'(word(64'h8000_0000 + 64'(4 * i))));
    end

    // Decoder stalled: buffer fills, fetch stops, then drains in order
    hold_reset(0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(20);
    chk("stall_req_n",     64'(req_log.size()), 64'd2);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_head_pc",   inst_pc,             64'h8000_0000);
    inst_ready = 1'b1;
    step(20);
    chk("drain_pc0", pop_pc[0],  64'h8000_0000);
    chk("drain_pc1", pop_pc[1],  64'h8000_0004);
    chk("drain_pc2", pop_pc[2],  64'h8000_0008);
    chk("drain_req2", req_log[2], 64'h8000_0008);

    // Redirect while waiting for the response to 0x80000004
    hold_reset(3, 1'b1, 1'b1);
    rst_n = 1'b1;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step(1);
      if (req_log.size() == 2) hit = 1;
    end
    chk("wait_redir_timeout", 64'(hit), 64'd1);
    redirect(64'h8000_1000);
    step(30);
    chk("wait_redir_pc0",  pop_pc[0],        64'h8000_0000);
    chk("wait_redir_pc1",  pop_pc[1],        64'h8000_1000);
    chk("wait_redir_inst", 64'(pop_inst[1]), 64'(word(64'h8000_1000)));
    chk("wait_redir_req2", req_log[2],       64'h8000_1000);

    // Redirect while a request is stalled on the imem port
    hold_reset(0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step(2);
    imem_req_ready = 1'b1;
    step(1);
    imem_req_ready = 1'b0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1);
      if (imem_req_valid && imem_req_addr == 64'h8000_0004) hit = 1;
    end
    chk("req_redir_timeout", 64'(hit), 64'd1);
    redirect(64'h8000_2000);
    step(3);
    chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
    chk("req_hold_addr",  imem_req_addr,       64'h8000_0004);
    imem_req_ready = 1'b1;
    step(20);
    chk("req_redir_req1", req_log[1], 64'h8000_0004);
    chk("req_redir_req2", req_log[2], 64'h8000_2000);
    chk("req_redir_pc1",  pop_pc[1],  64'h8000_2000);

    // Redirect coinciding with response and pop, buffer going full
    hold_reset(2, 1'b1, 1'b0);
    rst_n = 1'b1;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step(1);
      if (imem_resp_valid && req_log.size() == 2) hit = 1;
    end
    chk("coll_timeout", 64'(hit), 64'd1);
    inst_ready = 1'b1;
    redirect(64'h8000_3000);
    chk("coll_inst_valid", 64'(inst_valid), 64'd0);
    step(20);
    chk("coll_pc0",  pop_pc[0],  64'h8000_3000);
    chk("coll_req2", req_log[2], 64'h8000_3000);

    // PC wraps at the top of the address space
    hold_reset(0, 1'b1, 1'b1);
    rst_n = 1'b1;
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    step(12);
    chk("wrap_req_n", 64'(req_log.size() >= 2), 64'd1);
    chk("wrap_req0",  req_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_req1",  req_log[1], 64'h0);
    chk("wrap_inst1", 64'(pop_inst[1]), 64'h1357_9BDF);

    // Misaligned redirect
    hold_reset(0, 1'b1, 1'b0);
    rst_n = 1'b1;
    redirect(64'h8000_0002);
    step(10);
`ifdef YSYX_22041207_IFU_MISALIGN_EN
    chk("mis_req_n",    64'(req_log.size()), 64'd0);
    chk("mis_valid",    64'(inst_valid),     64'd1);
    chk("mis_inst",     64'(inst),           64'h13);
    chk("mis_pc",       inst_pc,             64'h8000_0002);
    chk("mis_flag",     64'(fetch_misalign), 64'd1);
`else
    chk("mis_req0",     req_log[0],          64'h8000_0000);
    chk("mis_pc",       inst_pc,             64'h8000_0000);
    chk("mis_flag",     64'(fetch_misalign), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
